branch_target_buffer: RTL and testbench
=======================================

// Module: branch_target_buffer
// PURPOSE
//  Direct-mapped branch target buffer with 2-bit saturating direction counters for the pipelined core.
//  Looked up in IF with the current PC to steer pc_next speculatively.
//  Updated from EX when a branch or jump resolves, which removes the fixed flush on every taken branch.
//  Keeps saturating performance counters for lookups, hits and mispredicts.
// PARAMETERS
//  DEPTH     16  entries; power of 2, >=2; IDX_W = $clog2(DEPTH)
//  TAG_W     30-IDX_W  tag width; tag = pc[31:IDX_W+2]
//  PERF_W    32  width of each performance counter
//  ALLOC_NT  0   1 = also allocate on a not-taken miss (counter WEAK_NT); 0 = allocate on taken only
// PORTS
//  CLK              in   1       clock
//  nRST             in   1       reset; asynchronous, active-low
//  stall            in   1       1 = hold; no table or perf update (e.g. !ihit)
//  clear            in   1       synchronous invalidate of all entries; perf counters kept
//  lookup_pc        in   32      IF-stage PC (word aligned)
//  pred_hit         out  1       valid entry with matching tag
//  pred_taken       out  1       pred_hit & counter[1]
//  pred_target      out  32      stored target when pred_taken, else lookup_pc+4
//  upd_en           in   1       EX resolved a control-flow instruction this cycle
//  upd_pc           in   32      PC of the resolved instruction
//  upd_taken        in   1       actual direction
//  upd_target       in   32      actual taken target
//  upd_mispredict   in   1       EX detected a direction or target mismatch (counted only)
//  perf_lookups     out  PERF_W  lookups performed
//  perf_hits        out  PERF_W  lookups with pred_hit
//  perf_mispred     out  PERF_W  updates with upd_mispredict
// BEHAVIOUR
//  Reset (async): all valid=0, all counters WEAK_NT (2'b01), tags/targets 0, perf counters 0.
//  Lookup is combinational (0-cycle): idx=lookup_pc[IDX_W+1:2].
//   - Miss: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4 (wraps mod 2^32).
//  Update on posedge when upd_en & !stall & !clear; idx/tag come from upd_pc.
//   - Tag hit: counter increments if taken, else decrements.
//     Saturates at STRONG_T(11) and STRONG_NT(00).
//     Target is overwritten with upd_target only when taken.
//   - Miss with upd_taken: allocate or replace; valid=1, tag, target, counter=WEAK_T(10).
//   - Miss with !upd_taken: allocate only if ALLOC_NT (counter WEAK_NT, target 0); otherwise no change.
//  Simultaneous lookup and update to the same index: the lookup sees pre-update contents (read-before-write, no bypass).
//  clear wins over upd_en in the same cycle.
//   - All valid bits drop at the edge.
//   - Counters reset to WEAK_NT.
//   - Perf counters are unaffected.
//  stall=1: table and perf counters frozen; lookup outputs still reflect the current lookup_pc.
//  Perf counters: each increments by 1 per qualifying non-stalled cycle.
//   - perf_lookups: every cycle.
//   - perf_hits: when pred_hit.
//   - perf_mispred: when upd_en & upd_mispredict.
//   - Each counter saturates at all-ones; it never wraps.
//  Reset asserted mid-operation: immediate return to reset state; no partial entry writes survive.
// STRUCTURE
//  cpu_types_pkg additions:
//   - typedef enum logic [1:0] {STRONG_NT, WEAK_NT, WEAK_T, STRONG_T} bp_state_t
//   - typedef struct packed {logic valid; logic [TAG_W-1:0] tag; word_t target; bp_state_t ctr;} btb_entry_t
//     (TAG_W is a module parameter, so the struct is declared in the module via typedef inside a generate-free scope)
//  Sub-module: bp_sat_ctr
//   - Combinational next-state of bp_state_t given the taken bit.
//   - Instantiated once on the update path.
//  Table storage: flops (DEPTH small); no SRAM macro.
// TESTING
//  1 Reset, lookup 0x0000_0040 -> pred_hit=0, pred_taken=0, pred_target=0x0000_0044; all perf counters 0.
//  2 Update pc=0x40 taken target=0x100; next cycle lookup 0x40 -> hit, taken, target 0x100, ctr WEAK_T.
//    Then not-taken x2 -> ctr STRONG_NT, pred_taken=0; a third not-taken keeps STRONG_NT.
//  3 Aliasing (DEPTH=16): update pc=0x40 taken, then pc=0x80 taken target 0x200 (same idx).
//    Lookup 0x40 -> miss; lookup 0x80 -> target 0x200.
//  4 Same-cycle lookup and update of 0x40 from empty: that cycle pred_hit=0; the following cycle pred_hit=1.
//    With clear and upd_en together: entry not written, all valid=0.
//  5 stall=1 with upd_en for 5 cycles -> table and perf unchanged.
//    PERF_W=4: 20 hit lookups -> perf_hits=15 (saturated).
//  6 Assert nRST low mid-stream after table fill -> outputs immediately at reset values; subsequent lookups miss.

Source files
------------

// File: rtl/branch_target_buffer_pkg.sv
// Shared types for the branch target buffer: direction-counter encoding and word type.
// Lookup/update helpers used by the BTB and its sub-module.
package branch_target_buffer_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bp_state_t;

    localparam word_t INSN_BYTES = 32'd4;

    // Fall-through address; wraps naturally at the top of the address space.
    function automatic word_t seq_pc(input word_t pc);
        return pc + INSN_BYTES;
    endfunction

    function automatic logic predicts_taken(input bp_state_t s);
        return (s == WEAK_T) || (s == STRONG_T);
    endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// IF-stage lookup, EX-stage update and performance-counter bundle of the BTB.
// The core side drives through master; the BTB answers through slave.
interface branch_target_buffer_if #(
    parameter int PERF_W = 32
);
    logic                         stall;
    logic                         clear;
    branch_target_buffer_pkg::word_t lookup_pc;
    logic                         pred_hit;
    logic                         pred_taken;
    branch_target_buffer_pkg::word_t pred_target;
    logic                         upd_en;
    branch_target_buffer_pkg::word_t upd_pc;
    logic                         upd_taken;
    branch_target_buffer_pkg::word_t upd_target;
    logic                         upd_mispredict;
    logic [PERF_W-1:0]            perf_lookups;
    logic [PERF_W-1:0]            perf_hits;
    logic [PERF_W-1:0]            perf_mispred;

    modport master (
        output stall, clear, lookup_pc,
        output upd_en, upd_pc, upd_taken, upd_target, upd_mispredict,
        input  pred_hit, pred_taken, pred_target,
        input  perf_lookups, perf_hits, perf_mispred
    );

    modport slave (
        input  stall, clear, lookup_pc,
        input  upd_en, upd_pc, upd_taken, upd_target, upd_mispredict,
        output pred_hit, pred_taken, pred_target,
        output perf_lookups, perf_hits, perf_mispred
    );
endinterface

// File: rtl/branch_target_buffer_bp_sat_ctr.sv
// 2-bit saturating direction counter next-state; purely combinational, 0-cycle.
// No handshake: the caller decides when the result is committed.
module bp_sat_ctr
    import branch_target_buffer_pkg::*;
(
    input  bp_state_t ctr_i,
    input  logic      taken_i,
    output bp_state_t ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        case (ctr_i)
            STRONG_NT: ctr_o = taken_i ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   ctr_o = taken_i ? WEAK_T   : STRONG_NT;
            WEAK_T:    ctr_o = taken_i ? STRONG_T : WEAK_NT;
            STRONG_T:  ctr_o = taken_i ? STRONG_T : WEAK_T;
            default:   ctr_o = WEAK_NT;
        endcase
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit direction counters and saturating perf counters.
// Lookup is 0-cycle combinational, updates commit at the edge; stall freezes all state.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int PERF_W   = 32,
    parameter bit ALLOC_NT = 1'b0
) (
    input  logic                  CLK,
    input  logic                  nRST,
    branch_target_buffer_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = 30 - IDX_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        word_t            target;
        bp_state_t        ctr;
    } btb_entry_t;

    localparam btb_entry_t RST_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
    localparam logic [PERF_W-1:0] PERF_ONE = 1;

    btb_entry_t table_q [DEPTH];
    btb_entry_t table_d [DEPTH];

    logic [PERF_W-1:0] lookups_q, lookups_d;
    logic [PERF_W-1:0] hits_q,    hits_d;
    logic [PERF_W-1:0] mispred_q, mispred_d;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + PERF_ONE : v;
    endfunction

    // Lookup path: reads the registered table, so a same-cycle update is not visible.
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    btb_entry_t       lk_entry;
    logic             lk_hit;
    logic             lk_taken;

    assign lk_idx   = bus.lookup_pc[IDX_W+1:2];
    assign lk_tag   = bus.lookup_pc[31:IDX_W+2];
    assign lk_entry = table_q[lk_idx];
    assign lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);
    assign lk_taken = lk_hit && predicts_taken(lk_entry.ctr);

    assign bus.pred_hit    = lk_hit;
    assign bus.pred_taken  = lk_taken;
    assign bus.pred_target = lk_taken ? lk_entry.target : seq_pc(bus.lookup_pc);

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    btb_entry_t       upd_entry;
    logic             upd_hit;
    bp_state_t        upd_ctr_next;

    assign upd_idx   = bus.upd_pc[IDX_W+1:2];
    assign upd_tag   = bus.upd_pc[31:IDX_W+2];
    assign upd_entry = table_q[upd_idx];
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

    bp_sat_ctr u_sat_ctr (
        .ctr_i   (upd_entry.ctr),
        .taken_i (bus.upd_taken),
        .ctr_o   (upd_ctr_next)
    );

    // A stalled cycle also defers clear; the core re-presents it once unstalled.
    always_comb begin
        table_d = table_q;
        if (!bus.stall) begin
            if (bus.clear) begin
                for (int i = 0; i < DEPTH; i++) begin
                    table_d[i].valid = 1'b0;
                    table_d[i].ctr   = WEAK_NT;
                end
            end else if (bus.upd_en) begin
                if (upd_hit) begin
                    table_d[upd_idx].ctr = upd_ctr_next;
                    if (bus.upd_taken) begin
                        table_d[upd_idx].target = bus.upd_target;
                    end
                end else if (bus.upd_taken) begin
                    table_d[upd_idx] = '{valid: 1'b1, tag: upd_tag,
                                         target: bus.upd_target, ctr: WEAK_T};
                end else if (ALLOC_NT) begin
                    table_d[upd_idx] = '{valid: 1'b1, tag: upd_tag,
                                         target: '0, ctr: WEAK_NT};
                end
            end
        end
    end

    always_comb begin
        lookups_d = sat_inc(lookups_q, !bus.stall);
        hits_d    = sat_inc(hits_q,    !bus.stall && lk_hit);
        mispred_d = sat_inc(mispred_q, !bus.stall && bus.upd_en && bus.upd_mispredict);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= RST_ENTRY;
            end
            lookups_q <= '0;
            hits_q    <= '0;
            mispred_q <= '0;
        end else begin
            table_q   <= table_d;
            lookups_q <= lookups_d;
            hits_q    <= hits_d;
            mispred_q <= mispred_d;
        end
    end

    assign bus.perf_lookups = lookups_q;
    assign bus.perf_hits    = hits_q;
    assign bus.perf_mispred = mispred_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: directed vectors queue expected predictions,
// a negedge monitor pops and compares them against the combinational outputs.
module tb_branch_target_buffer;
    import branch_target_buffer_pkg::*;

    localparam int PW   = 4;
    localparam int PMAX = (1 << PW) - 1;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    branch_target_buffer_if #(.PERF_W(PW)) bus ();

    branch_target_buffer #(
        .DEPTH    (16),
        .PERF_W   (PW),
        .ALLOC_NT (1'b0)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        int          lk;
        int          ht;
        int          mp;
    } exp_t;

    exp_t sb[$];
    logic chk_vld  = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_lk = 0, m_ht = 0, m_mp = 0;

    function automatic int sat(input int v);
        return (v >= PMAX) ? PMAX : v + 1;
    endfunction

    function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
    endfunction

    // Monitor: one expected record per checked cycle, sampled mid-cycle.
    always @(negedge CLK) begin
        if (chk_vld) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL sb_underflow: got empty queue, expected a record");
            end else begin
                exp_t e;
                e = sb.pop_front();
                cmp({e.name, ".hit"},     {31'd0, bus.pred_hit},   {31'd0, e.hit});
                cmp({e.name, ".taken"},   {31'd0, bus.pred_taken}, {31'd0, e.taken});
                cmp({e.name, ".target"},  bus.pred_target,         e.tgt);
                cmp({e.name, ".lookups"}, 32'(bus.perf_lookups),   32'(e.lk));
                cmp({e.name, ".hits"},    32'(bus.perf_hits),      32'(e.ht));
                cmp({e.name, ".mispred"}, 32'(bus.perf_mispred),   32'(e.mp));
            end
        end
    end

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input logic mp);
        bus.upd_en         = 1'b1;
        bus.upd_pc         = pc;
        bus.upd_taken      = tk;
        bus.upd_target     = tg;
        bus.upd_mispredict = mp;
    endtask

    task automatic idle_inputs();
        bus.upd_en         = 1'b0;
        bus.upd_pc         = 32'd0;
        bus.upd_taken      = 1'b0;
        bus.upd_target     = 32'd0;
        bus.upd_mispredict = 1'b0;
        bus.stall          = 1'b0;
        bus.clear          = 1'b0;
    endtask

    // One clock of stimulus: expectations use the perf model as of this cycle.
    task automatic look(input string nm, input logic [31:0] pc,
                        input logic eh, input logic et, input logic [31:0] etg);
        exp_t e;
        logic st, cnt_mp;
        bus.lookup_pc = pc;
        e = '{name: nm, hit: eh, taken: et, tgt: etg, lk: m_lk, ht: m_ht, mp: m_mp};
        sb.push_back(e);
        st     = bus.stall;
        cnt_mp = bus.upd_en && bus.upd_mispredict;
        chk_vld = 1'b1;
        @(posedge CLK);
        #1;
        chk_vld = 1'b0;
        if (!st) begin
            m_lk = sat(m_lk);
            if (eh)     m_ht = sat(m_ht);
            if (cnt_mp) m_mp = sat(m_mp);
        end
        idle_inputs();
    endtask

    // Reset asserted mid-cycle: outputs must drop before any further clock edge.
    task automatic rst_look(input string nm, input logic [31:0] pc);
        exp_t e;
        nRST = 1'b0;
        bus.lookup_pc = pc;
        m_lk = 0; m_ht = 0; m_mp = 0;
        e = '{name: nm, hit: 1'b0, taken: 1'b0, tgt: pc + 32'd4, lk: 0, ht: 0, mp: 0};
        sb.push_back(e);
        chk_vld = 1'b1;
        @(posedge CLK);
        #1;
        chk_vld = 1'b0;
        nRST = 1'b1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        bus.lookup_pc = 32'd0;
        @(posedge CLK);
        #1;

        rst_look("reset", 32'h0000_0040);

        upd(32'h40, 1'b1, 32'h100, 1'b0);         look("rbw_first", 32'h40, 0, 0, 32'h44);
        look("alloc_wt", 32'h40, 1, 1, 32'h100);
        upd(32'h40, 1'b0, 32'hDEAD_0000, 1'b0);   look("wt_nt1", 32'h40, 1, 1, 32'h100);
        upd(32'h40, 1'b0, 32'hDEAD_0000, 1'b0);   look("wnt_nt2", 32'h40, 1, 0, 32'h44);
        upd(32'h40, 1'b0, 32'hDEAD_0000, 1'b0);   look("snt_nt3", 32'h40, 1, 0, 32'h44);
        upd(32'h40, 1'b1, 32'h120, 1'b1);         look("snt_hold", 32'h40, 1, 0, 32'h44);
        upd(32'h40, 1'b1, 32'h140, 1'b0);         look("wnt_t", 32'h40, 1, 0, 32'h44);
        bus.upd_mispredict = 1'b1;                look("wt_newtgt", 32'h40, 1, 1, 32'h140);
        upd(32'h40, 1'b1, 32'h140, 1'b0);         look("wt_t", 32'h40, 1, 1, 32'h140);
        upd(32'h40, 1'b1, 32'h140, 1'b0);         look("st_t", 32'h40, 1, 1, 32'h140);
        upd(32'h40, 1'b0, 32'h0000_BAD0, 1'b0);   look("st_hold", 32'h40, 1, 1, 32'h140);
        look("st_to_wt", 32'h40, 1, 1, 32'h140);

        upd(32'h80, 1'b1, 32'h200, 1'b0);         look("alias_rbw", 32'h80, 0, 0, 32'h84);
        look("alias_old", 32'h40, 0, 0, 32'h44);
        look("alias_new", 32'h80, 1, 1, 32'h200);

        upd(32'h44, 1'b0, 32'h500, 1'b0);         look("nt_miss", 32'h44, 0, 0, 32'h48);
        look("nt_noalloc", 32'h44, 0, 0, 32'h48);

        upd(32'h3C, 1'b1, 32'hFFFF_FFF0, 1'b0);   look("wrap_miss", 32'hFFFF_FFFC, 0, 0, 32'h0);
        look("idx15_hit", 32'h3C, 1, 1, 32'hFFFF_FFF0);
        look("idx15_tagmiss", 32'hFFFF_FFFC, 0, 0, 32'h0);

        for (int i = 0; i < 5; i++) begin
            upd(32'h44, 1'b1, 32'h300, 1'b1);
            bus.stall = 1'b1;
            look("stall", 32'h80, 1, 1, 32'h200);
        end
        look("post_stall", 32'h44, 0, 0, 32'h48);

        upd(32'h48, 1'b1, 32'h400, 1'b0);
        bus.clear = 1'b1;                         look("clear_cyc", 32'h80, 1, 1, 32'h200);
        look("clr_80", 32'h80, 0, 0, 32'h84);
        look("clr_48", 32'h48, 0, 0, 32'h4C);
        look("clr_3c", 32'h3C, 0, 0, 32'h40);

        rst_look("reset2", 32'h40);
        upd(32'h40, 1'b1, 32'h100, 1'b0);         look("sat_alloc", 32'h40, 0, 0, 32'h44);
        for (int i = 0; i < 20; i++) begin
            upd(32'h40, 1'b1, 32'h100, 1'b1);
            look("sat_hit", 32'h40, 1, 1, 32'h100);
        end
        look("sat_final", 32'h40, 1, 1, 32'h100);

        rst_look("mid_reset", 32'h40);
        look("post_rst_40", 32'h40, 0, 0, 32'h44);
        look("post_rst_3c", 32'h3C, 0, 0, 32'h40);

        repeat (2) @(posedge CLK);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL sb_drain: got %0d records left, expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
